fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin write-port arbiter for the shared synchronous byte FIFO.
//   Up to NUM_REQ producers request access; one owner at a time is granted
//   a burst of up to MAX_BURST words.
//   The arbiter drives the FIFO write strobe and data, and honours buf_full.
//   Sits directly in front of the FIFO write port; the read side is untouched.
// PARAMETERS
//   NUM_REQ    4  number of producers (>=2)
//   DW         8  data width; matches the FIFO buf_in width
//   MAX_BURST  4  max words written per grant (>=1)
// PORTS
//   clk           in   1            single clock, all state on rising edge
//   rst           in   1            asynchronous, active-low reset
//   arb_en        in   1            1 = new grants allowed
//   req           in   NUM_REQ      producer i has a word ready (level)
//   req_data      in   NUM_REQ*DW   producer i data at [i*DW +: DW]
//   ack           out  NUM_REQ      comb; word of producer i accepted this cycle
//   gnt           out  NUM_REQ      registered one-hot current owner (0 = none)
//   busy          out  1            registered; 1 while in BURST
//   fifo_full     in   1            FIFO buf_full
//   fifo_wr_en    out  1            comb; FIFO wr_en
//   fifo_wr_data  out  DW           comb; FIFO buf_in
// BEHAVIOUR
//   Reset (rst=0, async):
//   - state=IDLE, gnt=0, busy=0, beat_cnt=0, last_owner=NUM_REQ-1.
//   - ack, fifo_wr_en are 0; fifo_wr_data=0. Reset mid-burst aborts it, no partial state.
//   FSM: IDLE, BURST.
//   - IDLE: if arb_en && |req at edge:
//     - owner = first i with req[i], searching last_owner+1, +2, ... mod NUM_REQ.
//     - gnt<=onehot(owner), busy<=1, beat_cnt<=0, ->BURST.
//     - fifo_full is ignored for the grant decision.
//   - BURST: xfer = req[owner] && !fifo_full.
//     - ack[owner]=xfer.
//     - fifo_wr_en=xfer; fifo_wr_data=req_data[owner] when xfer, else 0.
//     - On xfer, beat_cnt++. fifo_full stalls: no write, no ack, beat_cnt held, stay in BURST.
//   - Burst end, evaluated at the edge:
//     - (xfer && beat_cnt==MAX_BURST-1) || !req[owner]
//     - -> IDLE, gnt<=0, busy<=0, last_owner<=owner.
//   - One dead IDLE cycle between bursts (arbitration bubble).
//   - Grant-to-first-write latency: 1 cycle after the grant edge.
//   Rules:
//   - ack/fifo_wr_en never asserted outside BURST or for a non-owner.
//   - Producer holds req_data stable until its ack; ack consumes exactly one word.
//   - arb_en=0 never truncates an active burst; it only blocks the IDLE->BURST grant.
//   - beat_cnt width = $clog2(MAX_BURST+1); never exceeds MAX_BURST-1 while in BURST.
//   - Sole requester re-wins after the bubble (round-robin wraps to itself).
//   - Persistent fifo_full holds BURST indefinitely; no timeout.
// TESTING
//   1. rst=0 mid-stream -> gnt=0, busy=0, ack=0, fifo_wr_en=0 within the same cycle.
//   2. Only req[2]=1, data 0x10..0x17 advanced on ack:
//      -> bursts of 4 writes (0x10-0x13, 0x14-0x17) to owner 2, one idle cycle between.
//   3. req=4'b1111 continuous -> gnt order 0,1,2,3,0.
//      -> each burst 4 fifo_wr_en cycles + 1 bubble; 5 cycles per grant.
//   4. fifo_full=1 for 3 cycles after beat 1 of owner 0:
//      -> no ack/wr_en for 3 cycles, then beats 2-4; exactly 4 words written.
//   5. Owner 1 drops req after 2 beats with req=4'b1011 -> burst ends.
//      -> next grant goes to owner 3 (search from 2).
//   6. arb_en=0 during owner 0 burst -> burst completes 4 beats, gnt stays 0 until arb_en=1.
//      -> then the next owner is 1.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the shared byte FIFO: one producer owns the port for up to MAX_BURST words.
// First write lands 1 cycle after the grant edge; fifo_full stalls the burst in place, with one idle bubble between bursts.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arb_en,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    ack,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  busy,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DW-1:0]         fifo_wr_data
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state, state_nxt;
  logic [OW-1:0]        owner, owner_nxt;
  logic [OW-1:0]        last_owner, last_owner_nxt;
  logic [OW-1:0]        pick;
  logic                 pick_vld;
  logic [BW-1:0]        beat_cnt, beat_cnt_nxt;
  logic [NUM_REQ-1:0]   gnt_nxt;
  logic                 busy_nxt;
  logic                 xfer;

  function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int k);
    return OW'((int'(base) + k) % NUM_REQ);
  endfunction

  // Search starts just after the previous owner, so a sole requester wraps back to itself.
  always_comb begin
    pick     = last_owner;
    pick_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pick_vld && req[rr_idx(last_owner, k)]) begin
        pick     = rr_idx(last_owner, k);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    xfer         = (state == BURST) && req[owner] && !fifo_full;
    ack          = '0;
    fifo_wr_en   = xfer;
    fifo_wr_data = '0;
    if (xfer) begin
      ack[owner]   = 1'b1;
      fifo_wr_data = req_data[owner*DW +: DW];
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    gnt_nxt        = gnt;
    busy_nxt       = busy;
    case (state)
      IDLE: begin
        if (arb_en && pick_vld) begin
          state_nxt     = BURST;
          owner_nxt     = pick;
          gnt_nxt       = '0;
          gnt_nxt[pick] = 1'b1;
          busy_nxt      = 1'b1;
          beat_cnt_nxt  = '0;
        end
      end
      BURST: begin
        if (xfer) beat_cnt_nxt = beat_cnt + 1'b1;
        if ((xfer && beat_cnt == BW'(MAX_BURST - 1)) || !req[owner]) begin
          state_nxt      = IDLE;
          gnt_nxt        = '0;
          busy_nxt       = 1'b0;
          last_owner_nxt = owner;
          beat_cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(NUM_REQ - 1);
      beat_cnt   <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
      gnt        <= gnt_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule
